flit_demux: RTL and testbench
=============================

Name: flit_demux

Overview:
- 1-to-2 wormhole demultiplexer, the counterpart of the 2:1 flit mux used in the router characterization flow.
- Accepts HEAD/DATA/TAIL flits on one input port and steers each packet to output 0 or 1, selected by a destination bit in the HEAD flit.
- The route is held per virtual channel until the TAIL flit passes.
- Each output has a 2-entry buffer with valid/ready backpressure, so the block sits between the mux output and downstream router ports.

Parameters:
- DATA_W, 64, flit payload width (bits 63:0)
- TYPE_W, 2, flit type field width (top bits of flit)
- VCH_W, 1, virtual-channel id width; NUM_VCH = 2**VCH_W
- DST_BIT, 0, payload bit of HEAD flit selecting output (0 -> port 0, 1 -> port 1)
- CNT_W, 16, width of per-output flit counters

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- idata  in  TYPE_W+DATA_W  input flit {type, payload}
- ivalid  in  1  input flit valid
- ivch  in  VCH_W  input virtual channel
- iready  out  1  demux can accept the flit this cycle
- odata_0 / odata_1  out  TYPE_W+DATA_W  output flits
- ovalid_0 / ovalid_1  out  1  output valid
- ovch_0 / ovch_1  out  VCH_W  output virtual channel
- oready_0 / oready_1  in  1  downstream accepts
- err  out  1  one-cycle pulse on protocol violation
- fcnt_0 / fcnt_1  out  CNT_W  flits delivered per output, saturating

Behaviour:
- Types (package): NONE=2'b00, HEAD=2'b01, TAIL=2'b10, DATA=2'b11.
- Acceptance: a flit is accepted when ivalid && iready.
- Route table: per vch, holds lock bit and port bit.
- HEAD on an unlocked vch: target = payload[DST_BIT]. On accept, lock the vch with that port.
- DATA on a locked vch: target = locked port.
- TAIL on a locked vch: target = locked port. On accept, unlock the vch.
- iready = target FIFO not full. There is no same-cycle full bypass: a full FIFO deasserts iready even when that output's oready is high.
- Drop cases: iready=1, flit is not enqueued.
  - NONE with ivalid: dropped silently.
  - HEAD on a locked vch: dropped, err=1, lock kept.
  - DATA or TAIL on an unlocked vch: dropped, err=1.
- Output FIFOs: 2 entries each, storing {flit, vch}.
  - ovalid_n = FIFO non-empty; odata/ovch show the FIFO head.
  - Pop when ovalid_n && oready_n.
  - Push and pop in the same cycle are legal at any occupancy below full.
  - Latency: flit accepted in cycle t is visible at the output in cycle t+1.
  - Flit order is preserved per output.
  - Read/write pointers are 1 bit and wrap 1->0; a separate count 0..2 gives full/empty.
- Counters: fcnt_n increments on each pop and saturates at all ones (no wrap).
- Independent outputs: a stall on one output does not block flits bound for the other, including flits of another vch.
- Reset (synchronous, rst=1 at posedge):
  - All route locks clear, FIFOs empty.
  - ovalid_n=0, odata_n=0, ovch_n=0, fcnt_n=0, err=0.
  - iready evaluates combinationally; with FIFOs empty it is 1.
  - Reset mid-packet discards the partial packet. A later DATA on that vch raises err.
- err is registered: asserted the cycle after the violating accept, for exactly one cycle per violation.

Decomposition:
- Package flit_pkg holds:
  - type constants (NONE/HEAD/TAIL/DATA);
  - TYPE_W and DATA_W defaults;
  - a function extracting the type field from a flit.
- One sub-module, flit_fifo2: 2-entry valid/ready FIFO, instantiated twice.
- Route table and classification logic stay in flit_demux.

Test Plan:
- Basic routing.
  - Stimulus: HEAD payload 0x09 on vch 0, then 20 DATA, then TAIL; oready_0=oready_1=1.
  - Required: all 22 flits appear on output 1 in order, one cycle after each accept; fcnt_1=22, fcnt_0=0, err never set.
- Routing to port 0 with another vch.
  - Stimulus: HEAD 0x04 on vch 1, then 3 DATA, then TAIL.
  - Required: 5 flits on output 0; vch 1 lock clears after TAIL; a new HEAD 0x09 on vch 1 then routes to output 1.
- Backpressure.
  - Stimulus: oready_1=0 during a 20-DATA packet to port 1.
  - Required: after 2 accepts iready=0 and the FIFO holds 2 entries. Raising oready_1 drains in order; no loss or duplication.
- Independent outputs.
  - Stimulus: vch 0 locked to port 1 with oready_1=0; a HEAD 0x04 arrives on vch 1.
  - Required: it is accepted and appears on output 0 while output 1 stays stalled.
- Protocol errors.
  - Stimulus: DATA on unlocked vch 0, then HEAD on a locked vch.
  - Required: each is dropped with a one-cycle err pulse; output counters are unchanged.
- Reset mid-packet.
  - Stimulus: assert rst after HEAD plus 5 DATA have been sent.
  - Required: next cycle all outputs are 0 and FIFOs empty; a following DATA on that vch gives err=1.

Source files
------------

// File: rtl/flit_pkg.sv
// Shared flit definitions for the wormhole demux: type encodings, default widths
// and a helper that pulls the type field out of a packed flit.
package flit_pkg;

  localparam int TYPE_W = 2;
  localparam int DATA_W = 64;
  localparam int FLIT_W = TYPE_W + DATA_W;

  typedef enum logic [TYPE_W-1:0] {
    NONE = 2'b00,
    HEAD = 2'b01,
    TAIL = 2'b10,
    DATA = 2'b11
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[FLIT_W-1 -: TYPE_W]);
  endfunction

endpackage

// File: rtl/flit_fifo2.sv
// Two-entry valid/ready FIFO with 1-bit wrapping pointers and a separate 0..2 count.
// Full is taken from registered state only, so a pop never frees space for a push in the same cycle.
module flit_fifo2 #(
  parameter int W = 67
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         ovalid,
  output logic [W-1:0] odata,
  input  logic         oready
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    ovalid   = (count_q != 2'd0);
    full     = (count_q == 2'd2);
    do_pop   = ovalid && oready;
    do_push  = push && !full;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    odata    = ovalid ? mem_q[rd_ptr_q] : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; odata is gated by ovalid so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/flit_demux.sv
// 1-to-2 wormhole demultiplexer: HEAD flits pick an output and lock their virtual channel
// to it until TAIL; each output is buffered by a 2-entry FIFO with valid/ready backpressure.
module flit_demux #(
  parameter int DATA_W  = flit_pkg::DATA_W,
  parameter int TYPE_W  = flit_pkg::TYPE_W,
  parameter int VCH_W   = 1,
  parameter int DST_BIT = 0,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TYPE_W+DATA_W-1:0] idata,
  input  logic                     ivalid,
  input  logic [VCH_W-1:0]         ivch,
  output logic                     iready,
  output logic [TYPE_W+DATA_W-1:0] odata_0,
  output logic [TYPE_W+DATA_W-1:0] odata_1,
  output logic                     ovalid_0,
  output logic                     ovalid_1,
  output logic [VCH_W-1:0]         ovch_0,
  output logic [VCH_W-1:0]         ovch_1,
  input  logic                     oready_0,
  input  logic                     oready_1,
  output logic                     err,
  output logic [CNT_W-1:0]         fcnt_0,
  output logic [CNT_W-1:0]         fcnt_1
);

  import flit_pkg::*;

  localparam int NUM_VCH = 2 ** VCH_W;
  localparam int FLT_W   = TYPE_W + DATA_W;
  localparam int ENT_W   = FLT_W + VCH_W;

  logic [NUM_VCH-1:0] lock_q, lock_d;
  logic [NUM_VCH-1:0] port_q, port_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   fcnt_0_q, fcnt_0_d;
  logic [CNT_W-1:0]   fcnt_1_q, fcnt_1_d;

  flit_type_e         ftype;
  logic               target, enq, viol, accept;
  logic               push_0, push_1;
  logic               full_0, full_1;
  logic [ENT_W-1:0]   ent_0, ent_1;

  flit_fifo2 #(.W(ENT_W)) u_fifo_0 (
    .clk    (clk),
    .rst    (rst),
    .push   (push_0),
    .wdata  ({idata, ivch}),
    .full   (full_0),
    .ovalid (ovalid_0),
    .odata  (ent_0),
    .oready (oready_0)
  );

  flit_fifo2 #(.W(ENT_W)) u_fifo_1 (
    .clk    (clk),
    .rst    (rst),
    .push   (push_1),
    .wdata  ({idata, ivch}),
    .full   (full_1),
    .ovalid (ovalid_1),
    .odata  (ent_1),
    .oready (oready_1)
  );

  assign odata_0 = ent_0[ENT_W-1 -: FLT_W];
  assign ovch_0  = ent_0[VCH_W-1:0];
  assign odata_1 = ent_1[ENT_W-1 -: FLT_W];
  assign ovch_1  = ent_1[VCH_W-1:0];
  assign err     = err_q;
  assign fcnt_0  = fcnt_0_q;
  assign fcnt_1  = fcnt_1_q;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    ftype  = flit_type(idata);
    target = port_q[ivch];
    enq    = 1'b0;
    viol   = 1'b0;
    case (ftype)
      HEAD: begin
        if (lock_q[ivch]) viol = 1'b1;
        else begin
          target = idata[DST_BIT];
          enq    = 1'b1;
        end
      end
      DATA, TAIL: begin
        if (lock_q[ivch]) enq  = 1'b1;
        else              viol = 1'b1;
      end
      default: ;
    endcase

    // Dropped flits are always consumed; only a real enqueue waits on FIFO space.
    iready = !(enq && (target ? full_1 : full_0));
    accept = ivalid && iready;
    push_0 = accept && enq && !target;
    push_1 = accept && enq && target;

    lock_d = lock_q;
    port_d = port_q;
    if (accept && enq) begin
      if (ftype == HEAD) begin
        lock_d[ivch] = 1'b1;
        port_d[ivch] = target;
      end else if (ftype == TAIL) begin
        lock_d[ivch] = 1'b0;
      end
    end

    err_d    = accept && viol;
    fcnt_0_d = (ovalid_0 && oready_0 && !(&fcnt_0_q)) ? fcnt_0_q + CNT_W'(1) : fcnt_0_q;
    fcnt_1_d = (ovalid_1 && oready_1 && !(&fcnt_1_q)) ? fcnt_1_q + CNT_W'(1) : fcnt_1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q   <= '0;
      port_q   <= '0;
      err_q    <= 1'b0;
      fcnt_0_q <= '0;
      fcnt_1_q <= '0;
    end else begin
      lock_q   <= lock_d;
      port_q   <= port_d;
      err_q    <= err_d;
      fcnt_0_q <= fcnt_0_d;
      fcnt_1_q <= fcnt_1_d;
    end
  end

endmodule

// File: tb/tb_flit_demux.sv
// Directed bench for flit_demux: stimulus pushes expected {flit, vch} per output into
// scoreboard queues; an independent monitor pops and compares on every output handshake.
module tb_flit_demux;

  import flit_pkg::*;

  localparam int FW = 66;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] idata;
  logic          ivalid;
  logic          ivch;
  logic          iready;
  logic [FW-1:0] odata_0, odata_1;
  logic          ovalid_0, ovalid_1;
  logic          ovch_0, ovch_1;
  logic          oready_0, oready_1;
  logic          err;
  logic [15:0]   fcnt_0, fcnt_1;

  int n_vec = 0;
  int n_bad = 0;

  logic [FW:0] exp_q0 [$];
  logic [FW:0] exp_q1 [$];

  always #5 clk = ~clk;

  flit_demux dut (
    .clk      (clk),
    .rst      (rst),
    .idata    (idata),
    .ivalid   (ivalid),
    .ivch     (ivch),
    .iready   (iready),
    .odata_0  (odata_0),
    .odata_1  (odata_1),
    .ovalid_0 (ovalid_0),
    .ovalid_1 (ovalid_1),
    .ovch_0   (ovch_0),
    .ovch_1   (ovch_1),
    .oready_0 (oready_0),
    .oready_1 (oready_1),
    .err      (err),
    .fcnt_0   (fcnt_0),
    .fcnt_1   (fcnt_1)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor samples 2 time units after the falling edge, once stimulus has settled.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (ovalid_0 && oready_0) begin
        if (exp_q0.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL out0_unexpected: got %0h expected nothing", {odata_0, ovch_0});
        end else check("out0_flit", {odata_0, ovch_0}, exp_q0.pop_front());
      end
      if (ovalid_1 && oready_1) begin
        if (exp_q1.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL out1_unexpected: got %0h expected nothing", {odata_1, ovch_1});
        end else check("out1_flit", {odata_1, ovch_1}, exp_q1.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Called just after a falling edge; returns just after the falling edge following the accept.
  task automatic send(input flit_type_e t, input logic [63:0] pl, input logic v,
                      input int port, input logic exp_err, input bit lat);
    logic [FW-1:0] f;
    int waited;
    f      = {t, pl};
    idata  = f;
    ivch   = v;
    ivalid = 1'b1;
    #1;
    waited = 0;
    while (!iready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!iready) begin
      n_vec++; n_bad++;
      $display("FAIL iready_timeout: got iready=0 expected 1 for flit %0h", f);
      ivalid = 1'b0;
      return;
    end
    @(posedge clk);
    if (port == 0) exp_q0.push_back({f, v});
    else if (port == 1) exp_q1.push_back({f, v});
    @(negedge clk);
    ivalid = 1'b0;
    #1;
    check("err_after_accept", err, exp_err);
    if (lat && port == 0) check("latency_out0", {ovalid_0, odata_0, ovch_0}, {1'b1, f, v});
    if (lat && port == 1) check("latency_out1", {ovalid_1, odata_1, ovch_1}, {1'b1, f, v});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ivalid = 1'b0; idata = '0; ivch = 1'b0;
    oready_0 = 1'b1; oready_1 = 1'b1;
    idle(2);
    rst = 1'b0;
    #1;
    check("rst_ovalid", {ovalid_0, ovalid_1}, 2'b00);
    check("rst_odata", {odata_0, odata_1}, '0);
    check("rst_ovch", {ovch_0, ovch_1}, 2'b00);
    check("rst_fcnt", {fcnt_0, fcnt_1}, 32'd0);
    check("rst_err", err, 1'b0);
    check("rst_iready", iready, 1'b1);

    // Basic routing: payload 0x09 has bit 0 set -> output 1.
    send(HEAD, 64'h09, 1'b0, 1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) send(DATA, 64'hDA7A_0000_0000_0000 + 64'(i), 1'b0, 1, 1'b0, 1'b1);
    send(TAIL, 64'h7A11_0000_0000_0001, 1'b0, 1, 1'b0, 1'b1);
    idle(2);
    check("basic_fcnt_1", fcnt_1, 16'd22);
    check("basic_fcnt_0", fcnt_0, 16'd0);

    // vch 1 to port 0, then re-route vch 1 to port 1 after its TAIL.
    send(HEAD, 64'h04, 1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(DATA, 64'hB0B0_0000_0000_0000 + 64'(i), 1'b1, 0, 1'b0, 1'b1);
    send(TAIL, 64'h7A11_0000_0000_0002, 1'b1, 0, 1'b0, 1'b1);
    send(HEAD, 64'h09, 1'b1, 1, 1'b0, 1'b1);
    send(TAIL, 64'h7A11_0000_0000_0003, 1'b1, 1, 1'b0, 1'b1);
    idle(2);
    check("vch1_fcnt_0", fcnt_0, 16'd5);
    check("vch1_fcnt_1", fcnt_1, 16'd24);

    // Backpressure on output 1: two accepts fill the FIFO, no bypass while full.
    oready_1 = 1'b0;
    send(HEAD, 64'h09, 1'b0, 1, 1'b0, 1'b1);
    send(DATA, 64'hCC00_0000_0000_0000, 1'b0, 1, 1'b0, 1'b0);
    idata = {DATA, 64'hCC00_0000_0000_0001}; ivch = 1'b0; ivalid = 1'b1;
    #1;
    check("bp_iready_full", iready, 1'b0);
    idle(3);
    #1;
    check("bp_iready_still", iready, 1'b0);
    check("bp_head_held", {ovalid_1, odata_1}, {1'b1, HEAD, 64'h09});
    check("bp_fcnt_1", fcnt_1, 16'd24);
    oready_1 = 1'b1;
    for (int i = 1; i < 20; i++) send(DATA, 64'hCC00_0000_0000_0000 + 64'(i), 1'b0, 1, 1'b0, 1'b0);
    send(TAIL, 64'h7A11_0000_0000_0004, 1'b0, 1, 1'b0, 1'b0);
    idle(3);
    check("bp_drained_fcnt_1", fcnt_1, 16'd46);

    // Independent outputs: output 1 stalled, vch 1 still flows to output 0.
    oready_1 = 1'b0;
    send(HEAD, 64'h09, 1'b0, 1, 1'b0, 1'b1);
    send(DATA, 64'hEE00_0000_0000_0000, 1'b0, 1, 1'b0, 1'b0);
    send(HEAD, 64'h04, 1'b1, 0, 1'b0, 1'b1);
    check("ind_out1_stalled", {ovalid_1, odata_1, ovch_1}, {1'b1, HEAD, 64'h09, 1'b0});
    check("ind_fcnt_1", fcnt_1, 16'd46);
    send(TAIL, 64'h7A11_0000_0000_0005, 1'b1, 0, 1'b0, 1'b1);
    oready_1 = 1'b1;
    send(TAIL, 64'h7A11_0000_0000_0006, 1'b0, 1, 1'b0, 1'b0);
    idle(3);
    check("ind_fcnt_0", fcnt_0, 16'd7);
    check("ind_fcnt_1b", fcnt_1, 16'd49);

    // Protocol errors: DATA on unlocked vch, NONE silent, HEAD on locked vch keeps the lock.
    send(DATA, 64'hBAD0_0000_0000_0000, 1'b0, -1, 1'b1, 1'b0);
    idle(1);
    check("err_one_cycle_a", err, 1'b0);
    send(NONE, 64'h1, 1'b0, -1, 1'b0, 1'b0);
    idle(2);
    check("err_fcnt_kept", {fcnt_0, fcnt_1}, {16'd7, 16'd49});
    send(HEAD, 64'h09, 1'b0, 1, 1'b0, 1'b1);
    send(HEAD, 64'h04, 1'b0, -1, 1'b1, 1'b0);
    idle(1);
    check("err_one_cycle_b", err, 1'b0);
    send(DATA, 64'hAB00_0000_0000_0000, 1'b0, 1, 1'b0, 1'b1);
    send(TAIL, 64'h7A11_0000_0000_0007, 1'b0, 1, 1'b0, 1'b1);
    idle(3);
    check("err_fcnt_after", {fcnt_0, fcnt_1}, {16'd7, 16'd52});

    // Reset mid-packet with two flits parked in output 1.
    send(HEAD, 64'h09, 1'b0, 1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(DATA, 64'h5E00_0000_0000_0000 + 64'(i), 1'b0, 1, 1'b0, 1'b1);
    oready_1 = 1'b0;
    send(DATA, 64'h5E00_0000_0000_0004, 1'b0, 1, 1'b0, 1'b0);
    check("pre_rst_valid_1", ovalid_1, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    check("mid_rst_ovalid", {ovalid_0, ovalid_1}, 2'b00);
    check("mid_rst_odata", {odata_0, odata_1}, '0);
    check("mid_rst_ovch", {ovch_0, ovch_1}, 2'b00);
    check("mid_rst_fcnt", {fcnt_0, fcnt_1}, 32'd0);
    check("mid_rst_err_iready", {err, iready}, 2'b01);
    oready_1 = 1'b1;
    send(DATA, 64'h5E00_0000_0000_0005, 1'b0, -1, 1'b1, 1'b0);
    idle(2);
    check("post_rst_nothing", {ovalid_0, ovalid_1, fcnt_0, fcnt_1}, '0);

    check("scoreboard_empty", exp_q0.size() + exp_q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
